// File: rtl/motor_drive_sched_if.sv
// motor_drive_sched_if: speed-command handshake into motor_drive_sched.
// Signals: cmd_vld (command valid), cmd_rdy (command ready),
//   lft_spd / rht_spd (signed 12-bit speed commands, two's complement).
// Modports: master drives commands, slave (the scheduler) drives cmd_rdy.
interface motor_drive_sched_if;
    logic               cmd_vld;
    logic               cmd_rdy;
    logic signed [11:0] lft_spd;
    logic signed [11:0] rht_spd;
    modport master (output cmd_vld, lft_spd, rht_spd, input cmd_rdy);
    modport slave  (input cmd_vld, lft_spd, rht_spd, output cmd_rdy);
endinterface

// File: rtl/motor_drive_sched.sv
// motor_drive_sched: slew-limited, reversal-safe duty/direction sequencer for two PWM channels.
// Ports: clk, rst (async, active-high), en (low ramps both channels to 0),
//   cmd (slave handshake: cmd_vld/cmd_rdy/lft_spd/rht_spd),
//   duty_lft/duty_rht (11-bit duty), rev_lft/rev_rht (1 = reverse),
//   tick (pulse at PWM period end), settled (both channels at target).
// Optional MOTOR_FAULT_LATCH_EN adds fault (in) and flt_latched (out).
module motor_drive_sched #(
    parameter int STEP         = 16,
    parameter int DEAD_PERIODS = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    motor_drive_sched_if.slave cmd,
`ifdef MOTOR_FAULT_LATCH_EN
    input  logic               fault,
    output logic               flt_latched,
`endif
    output logic [10:0]        duty_lft,
    output logic [10:0]        duty_rht,
    output logic               rev_lft,
    output logic               rev_rht,
    output logic               tick,
    output logic               settled
);
    typedef enum logic [1:0] {RUN, BRAKE, DEAD} state_t;
    localparam logic [11:0] STP = 12'(STEP);
    localparam logic [3:0]  DP  = 4'(DEAD_PERIODS);

    logic [10:0]        cnt_q, cnt_d;
    state_t             st_q [2], st_d [2];
    logic [10:0]        duty_q [2], duty_d [2];
    logic               rev_q [2], rev_d [2];
    logic [3:0]         dcnt_q [2], dcnt_d [2];
    logic signed [11:0] tgt_q [2], tgt_d [2];
    logic               settled_q, settled_d;
    logic [11:0]        mag_w [2];
    logic [10:0]        mag [2], ramp [2], brk [2];
    logic               dir [2];
    logic               rdy, xfer, kill, flt_q;

`ifdef MOTOR_FAULT_LATCH_EN
    logic flt_d;
    // Only an all-zero command accepted while fault is low releases the latch.
    assign flt_d = fault || (flt_q && !(xfer && cmd.lft_spd == '0 && cmd.rht_spd == '0));
    assign kill = flt_d;
    assign flt_latched = flt_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) flt_q <= 1'b0;
        else     flt_q <= flt_d;
    end
`else
    assign flt_q = 1'b0;
    assign kill  = 1'b0;
`endif

    assign tick        = &cnt_q;
    assign rdy         = !rst && ((st_q[0] != DEAD && st_q[1] != DEAD) || flt_q);
    assign xfer        = cmd.cmd_vld && rdy;
    assign cmd.cmd_rdy = rdy;
    assign duty_lft    = duty_q[0];
    assign duty_rht    = duty_q[1];
    assign rev_lft     = rev_q[0];
    assign rev_rht     = rev_q[1];
    assign settled     = settled_q;

    always_comb begin
        cnt_d     = cnt_q + 11'd1;
        settled_d = 1'b1;
        for (int i = 0; i < 2; i++) begin
            // A command accepted on a tick edge already drives that tick's update.
            tgt_d[i]  = kill ? '0 : xfer ? (i == 0 ? cmd.lft_spd : cmd.rht_spd) : tgt_q[i];
            mag_w[i]  = tgt_d[i][11] ? $unsigned(-tgt_d[i]) : $unsigned(tgt_d[i]);
            // Only -2048 leaves bit 11 set after negation; it saturates to full scale.
            mag[i]    = !en ? '0 : mag_w[i][11] ? 11'h7ff : mag_w[i][10:0];
            dir[i]    = (en && tgt_d[i] != '0) ? tgt_d[i][11] : rev_q[i];
            ramp[i]   = (mag[i] > duty_q[i])
                      ? (({1'b0, mag[i]} - {1'b0, duty_q[i]} > STP) ? 11'({1'b0, duty_q[i]} + STP) : mag[i])
                      : (({1'b0, duty_q[i]} - {1'b0, mag[i]} > STP) ? 11'({1'b0, duty_q[i]} - STP) : mag[i]);
            brk[i]    = ({1'b0, duty_q[i]} > STP) ? 11'({1'b0, duty_q[i]} - STP) : '0;
            st_d[i]   = st_q[i];
            duty_d[i] = duty_q[i];
            rev_d[i]  = rev_q[i];
            dcnt_d[i] = dcnt_q[i];
            if (kill) begin
                st_d[i]   = RUN;
                duty_d[i] = '0;
                dcnt_d[i] = '0;
            end else if (tick) begin
                if (st_q[i] == DEAD) begin
                    dcnt_d[i] = dcnt_q[i] + 4'd1;
                    if (dcnt_d[i] == DP) begin
                        rev_d[i] = !rev_q[i];
                        st_d[i]  = RUN;
                    end
                end else if (dir[i] == rev_q[i]) begin
                    st_d[i]   = RUN;
                    duty_d[i] = ramp[i];
                end else begin
                    // Braking straight into DEAD once the duty has reached zero.
                    duty_d[i] = brk[i];
                    st_d[i]   = (brk[i] == '0) ? DEAD : BRAKE;
                    dcnt_d[i] = '0;
                end
            end
            settled_d = settled_d && st_d[i] == RUN && duty_d[i] == mag[i]
                        && (dir[i] == rev_d[i] || mag[i] == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            settled_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                st_q[i]   <= RUN;
                duty_q[i] <= '0;
                rev_q[i]  <= 1'b0;
                dcnt_q[i] <= '0;
                tgt_q[i]  <= '0;
            end
        end else begin
            cnt_q     <= cnt_d;
            settled_q <= settled_d;
            for (int i = 0; i < 2; i++) begin
                st_q[i]   <= st_d[i];
                duty_q[i] <= duty_d[i];
                rev_q[i]  <= rev_d[i];
                dcnt_q[i] <= dcnt_d[i];
                tgt_q[i]  <= tgt_d[i];
            end
        end
    end
endmodule

// File: tb/tb_motor_drive_sched.sv
// tb_motor_drive_sched: scoreboard bench for motor_drive_sched against a period-level reference model.
module tb_motor_drive_sched;
    localparam int STEP = 256;
    localparam int DP   = 3;

    typedef struct {
        int dl;
        int dr;
        bit rl;
        bit rr;
        bit st;
        bit rdy;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [10:0] duty_lft, duty_rht;
    logic        rev_lft, rev_rht, tick, settled;
`ifdef MOTOR_FAULT_LATCH_EN
    logic        fault = 1'b0;
    logic        flt;
`endif

    motor_drive_sched_if bus ();

    motor_drive_sched #(.STEP(STEP), .DEAD_PERIODS(DP)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .cmd        (bus),
`ifdef MOTOR_FAULT_LATCH_EN
        .fault      (fault),
        .flt_latched(flt),
`endif
        .duty_lft   (duty_lft),
        .duty_rht   (duty_rht),
        .rev_lft    (rev_lft),
        .rev_rht    (rev_rht),
        .tick       (tick),
        .settled    (settled)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   pc;
    int   mduty [2];
    int   mdead [2];
    int   mt [2];
    bit   mrev [2];
    exp_t q [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mduty[i] = 0;
            mdead[i] = 0;
            mt[i]    = 0;
            mrev[i]  = 1'b0;
        end
    endtask

    function automatic bit model_rdy();
        return mdead[0] == 0 && mdead[1] == 0;
    endfunction

    // One PWM period boundary: per-channel slew toward target, brake, dead-time countdown.
    task automatic model_tick();
        exp_t e;
        bit   ok;
        ok = 1'b1;
        for (int i = 0; i < 2; i++) begin
            int m;
            bit d;
            m = !en ? 0 : (mt[i] < 0 ? -mt[i] : mt[i]);
            if (m > 2047) m = 2047;
            d = (en && mt[i] != 0) ? (mt[i] < 0) : mrev[i];
            if (mdead[i] > 0) begin
                mdead[i]--;
                if (mdead[i] == 0) mrev[i] = !mrev[i];
            end else if (d == mrev[i]) begin
                mduty[i] = (mduty[i] < m) ? ((mduty[i] + STEP < m) ? mduty[i] + STEP : m)
                                          : ((mduty[i] - STEP > m) ? mduty[i] - STEP : m);
            end else begin
                mduty[i] = (mduty[i] > STEP) ? mduty[i] - STEP : 0;
                if (mduty[i] == 0) mdead[i] = DP;
            end
            ok = ok && mdead[i] == 0 && mduty[i] == m && (d == mrev[i] || m == 0);
        end
        e.dl  = mduty[0];
        e.dr  = mduty[1];
        e.rl  = mrev[0];
        e.rr  = mrev[1];
        e.st  = ok;
        e.rdy = model_rdy();
        q.push_back(e);
    endtask

    // Called at a negedge with this cycle's inputs already driven.
    task automatic step(output bit done);
        bit x;
        chk("tick", tick, pc == 2047);
        if (bus.cmd_vld) chk("cmd_rdy_hold", bus.cmd_rdy, model_rdy());
        x = bus.cmd_vld && model_rdy();
        if (x) begin
            mt[0] = int'(bus.lft_spd);
            mt[1] = int'(bus.rht_spd);
        end
        done = (pc == 2047);
        if (done) model_tick();
        @(negedge clk);
        pc = (pc + 1) % 2048;
        if (x) bus.cmd_vld = 1'b0;
    endtask

    task automatic rst_checks();
        chk("rst_duty_lft", duty_lft, 0);
        chk("rst_duty_rht", duty_rht, 0);
        chk("rst_rev_lft", rev_lft, 0);
        chk("rst_rev_rht", rev_rht, 0);
        chk("rst_tick", tick, 0);
        chk("rst_cmd_rdy", bus.cmd_rdy, 0);
        chk("rst_settled", settled, 0);
    endtask

    function automatic int rnd_spd();
        case ($urandom_range(0, 5))
            0:       return 0;
            1:       return -2048;
            2:       return 2047;
            default: return int'($urandom_range(0, 4095)) - 2048;
        endcase
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (tick === 1'b1) begin
                @(posedge clk);
                #1;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow got tick expected none");
                end else begin
                    e = q.pop_front();
                    chk("duty_lft", duty_lft, e.dl);
                    chk("duty_rht", duty_rht, e.dr);
                    chk("rev_lft", rev_lft, e.rl);
                    chk("rev_rht", rev_rht, e.rr);
                    chk("settled", settled, e.st);
                    chk("cmd_rdy", bus.cmd_rdy, e.rdy);
                end
            end
        end
    end

    initial begin
        int off, eoff, l, r;
        bit ev, done, did_rst;
        bus.cmd_vld = 1'b0;
        bus.lft_spd = '0;
        bus.rht_spd = '0;
        did_rst = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_checks();
        rst = 1'b0;
        pc  = 0;
        for (int p = 0; p < 40; p++) begin
            off  = -1;
            eoff = -1;
            ev   = en;
            l    = 0;
            r    = 0;
            case (p)
                0:  begin off = 100; l = 100; r = 0; eoff = 50; ev = 1'b1; end
                2:  begin off = 2047; l = -2048; r = 300; end
                3:  begin off = 500; l = -2048; r = -300; end
                16: begin eoff = 10; ev = 1'b0; end
                22: begin eoff = 10; ev = 1'b1; end
                default: if (p > 24) begin
                    if ($urandom_range(0, 1) == 1) begin
                        off = ($urandom_range(0, 3) == 0) ? 2047 : int'($urandom_range(0, 2047));
                        l   = rnd_spd();
                        r   = rnd_spd();
                    end
                    if ($urandom_range(0, 7) == 0) begin
                        eoff = int'($urandom_range(0, 2047));
                        ev   = !en;
                    end
                end
            endcase
            done = 1'b0;
            while (!done) begin
                if (p == 24 && pc == 1000 && !did_rst) begin
                    rst = 1'b1;
                    #1;
                    rst_checks();
                    @(negedge clk);
                    @(negedge clk);
                    rst = 1'b0;
                    model_reset();
                    pc = 0;
                    did_rst = 1'b1;
                end
                if (pc == eoff) en = ev;
                if (pc == off && !bus.cmd_vld) begin
                    bus.cmd_vld = 1'b1;
                    bus.lft_spd = 12'(l);
                    bus.rht_spd = 12'(r);
                end
                step(done);
            end
        end
        repeat (2) @(negedge clk);
        chk("sb_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
